// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ex_pkg                                                           |
// | Purpose : Shared definitions for the ID/EX operand stage: RV32I opcode     |
// |           constants, ALU control codes, operand-source selectors and the   |
// |           packed EX-control record. It also holds the funct3 -> ALU map    |
// |           that R-type and I-type instructions share.                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ex_pkg;

  // Major opcodes, instruction[6:0]
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU control codes, shared with the downstream ALU block
  typedef logic [3:0] alu_ctl_t;
  localparam alu_ctl_t ALU_AND = 4'b0000;
  localparam alu_ctl_t ALU_OR  = 4'b0001;
  localparam alu_ctl_t ALU_ADD = 4'b0010;
  localparam alu_ctl_t ALU_XOR = 4'b0011;
  localparam alu_ctl_t ALU_SUB = 4'b0110;
  localparam alu_ctl_t ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_e;

  typedef struct packed {
    alu_ctl_t alu_ctl;
    src_a_e   src_a;
    src_b_e   src_b;
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     branch;
    logic     branch_ne;
  } ex_ctrl_t;

  // Control word of a bubble; also the reset value
  localparam ex_ctrl_t CTRL_NOP = '{
    alu_ctl:   ALU_ADD,
    src_a:     SRC_A_RS1,
    src_b:     SRC_B_RS2,
    regwrite:  1'b0,
    memread:   1'b0,
    memwrite:  1'b0,
    branch:    1'b0,
    branch_ne: 1'b0
  };

  // funct3 values the ALU supports for register/immediate arithmetic
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) ||
           (f3 == 3'b100) || (f3 == 3'b010);
  endfunction

  // sub selects SUB for funct3 000 (R-type funct7[5]; always 0 for I-type)
  function automatic alu_ctl_t f3_to_alu(input logic [2:0] f3, input logic sub);
    alu_ctl_t res;
    case (f3)
      3'b000:  res = sub ? ALU_SUB : ALU_ADD;
      3'b111:  res = ALU_AND;
      3'b110:  res = ALU_OR;
      3'b100:  res = ALU_XOR;
      3'b010:  res = ALU_SLT;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : ex_operand_stage_if                                            |
// | Purpose   : Bundles the decode-side inputs, MEM/WB forwarding inputs and   |
// |             the EX-side outputs of the operand stage.                      |
// | Modports  : master - pipeline/control side (drives id_*, flush, mem_*,     |
// |                      wb_*; observes id_stall and ex_*)                     |
// |             slave  - the ex_operand_stage block                            |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface ex_operand_stage_if
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) ();

  // Decode stage
  logic                  id_valid;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [6:0]            id_opcode;
  logic [2:0]            id_funct3;
  logic                  id_funct7_5;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [DATA_WIDTH-1:0] id_rs1_data;
  logic [DATA_WIDTH-1:0] id_rs2_data;
  logic [DATA_WIDTH-1:0] id_imm;
  logic                  flush;

  // Forwarding sources
  logic                  mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_result;
  logic                  wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_result;

  // Stage outputs
  logic                  id_stall;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] ex_A;
  logic [DATA_WIDTH-1:0] ex_B;
  alu_ctl_t              ex_ALUCtl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_branch;
  logic                  ex_branch_ne;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic                  ex_illegal;

  modport master (
    output id_valid, id_pc, id_opcode, id_funct3, id_funct7_5,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, flush,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    input  id_stall, ex_valid, ex_A, ex_B, ex_ALUCtl, ex_rd, ex_regwrite,
           ex_memread, ex_memwrite, ex_branch, ex_branch_ne, ex_store_data,
           ex_illegal
  );

  modport slave (
    input  id_valid, id_pc, id_opcode, id_funct3, id_funct7_5,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, flush,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    output id_stall, ex_valid, ex_A, ex_B, ex_ALUCtl, ex_rd, ex_regwrite,
           ex_memread, ex_memwrite, ex_branch, ex_branch_ne, ex_store_data,
           ex_illegal
  );

endinterface
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fwd_mux                                                          |
// | Purpose : Forwarding selector for one source operand. The MEM-stage result |
// |           has priority over the WB-stage result. With no match the         |
// |           register-file value is passed through. x0 never forwards.        |
// | Ports   : src_idx/reg_data  - registered source index and RF read data     |
// |           mem_*/wb_*        - producer write enables, dests and results    |
// |           data              - resolved operand value                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic [DATA_WIDTH-1:0] data
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == src_idx);
  assign w_wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src_idx);

  always_comb begin
    data = reg_data;
    if (w_mem_hit) begin
      data = mem_result;
    end else if (w_wb_hit) begin
      data = wb_result;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_operand_stage                                                 |
// | Purpose : ID/EX pipeline register of the RISC-V core. It decodes ALU       |
// |           control and operand sources, detects load-use hazards (one       |
// |           bubble per pair) and drops unsupported instructions with a       |
// |           one-cycle ex_illegal pulse. It also resolves MEM/WB forwarding   |
// |           on the registered sources to drive ex_A / ex_B / ex_ALUCtl.      |
// | Ports   : clk, rst_n - core clock, asynchronous active-low reset           |
// |           bus        - ex_operand_stage_if.slave (decode inputs, flush,    |
// |                        forwarding inputs, id_stall and all ex_* outputs)   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_operand_stage_if.slave  bus
);

  // ---------------------------------------------------------------- decode
  ex_ctrl_t w_ctrl;
  ex_ctrl_t w_ctrl_q;
  logic     w_illegal;
  logic     w_uses_rs1;
  logic     w_uses_rs2;
  logic     w_stall;
  logic     w_bubble;

  always_comb begin
    w_ctrl     = CTRL_NOP;
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (bus.id_opcode)
      OP_RTYPE: begin
        w_ctrl.alu_ctl  = f3_to_alu(bus.id_funct3, bus.id_funct7_5);
        w_ctrl.regwrite = 1'b1;
        w_uses_rs1      = 1'b1;
        w_uses_rs2      = 1'b1;
        w_illegal       = !f3_legal(bus.id_funct3);
      end
      OP_ITYPE: begin
        // instruction[30] belongs to the immediate here, so no SUB
        w_ctrl.alu_ctl  = f3_to_alu(bus.id_funct3, 1'b0);
        w_ctrl.src_b    = SRC_B_IMM;
        w_ctrl.regwrite = 1'b1;
        w_uses_rs1      = 1'b1;
        w_illegal       = !f3_legal(bus.id_funct3);
      end
      OP_LOAD: begin
        w_ctrl.src_b    = SRC_B_IMM;
        w_ctrl.memread  = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_uses_rs1      = 1'b1;
      end
      OP_STORE: begin
        // rs2 is the store data, carried on ex_store_data
        w_ctrl.src_b    = SRC_B_IMM;
        w_ctrl.memwrite = 1'b1;
        w_uses_rs1      = 1'b1;
        w_uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.alu_ctl   = ALU_SUB;
        w_ctrl.branch    = 1'b1;
        w_ctrl.branch_ne = bus.id_funct3[0];
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
        w_illegal        = (bus.id_funct3[2:1] != 2'b00);
      end
      OP_LUI: begin
        w_ctrl.src_a    = SRC_A_ZERO;
        w_ctrl.src_b    = SRC_B_IMM;
        w_ctrl.regwrite = 1'b1;
      end
      OP_AUIPC: begin
        w_ctrl.src_a    = SRC_A_PC;
        w_ctrl.src_b    = SRC_B_IMM;
        w_ctrl.regwrite = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Side-effect flags only survive for a valid instruction
  always_comb begin
    w_ctrl_q           = w_ctrl;
    w_ctrl_q.regwrite  = w_ctrl.regwrite  & bus.id_valid;
    w_ctrl_q.memread   = w_ctrl.memread   & bus.id_valid;
    w_ctrl_q.memwrite  = w_ctrl.memwrite  & bus.id_valid;
    w_ctrl_q.branch    = w_ctrl.branch    & bus.id_valid;
    w_ctrl_q.branch_ne = w_ctrl.branch_ne & bus.id_valid;
  end

  // ---------------------------------------------------------- ID/EX register
  logic                  r_valid;
  ex_ctrl_t              r_ctrl;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_illegal;

  // The load sits in EX for one cycle only, so the bubble it causes
  // clears r_valid and the stall cannot repeat for the same pair.
  assign w_stall = bus.id_valid && !bus.flush && r_valid && r_ctrl.memread &&
                   (r_rd != '0) &&
                   (((r_rd == bus.id_rs1) && w_uses_rs1) ||
                    ((r_rd == bus.id_rs2) && w_uses_rs2));

  assign w_bubble = bus.flush || w_stall || (w_illegal && bus.id_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_illegal  <= 1'b0;
    end else if (w_bubble) begin
      // Bubble fields are zeroed so ex_A/ex_B stay deterministic
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_illegal  <= !bus.flush && !w_stall && w_illegal && bus.id_valid;
    end else begin
      r_valid    <= bus.id_valid;
      r_ctrl     <= w_ctrl_q;
      r_pc       <= bus.id_pc;
      r_imm      <= bus.id_imm;
      r_rs1_data <= bus.id_rs1_data;
      r_rs2_data <= bus.id_rs2_data;
      r_rs1      <= bus.id_rs1;
      r_rs2      <= bus.id_rs2;
      r_rd       <= bus.id_rd;
      r_illegal  <= 1'b0;
    end
  end

  // ------------------------------------------------------------- forwarding
  logic [DATA_WIDTH-1:0] w_fwd_rs1;
  logic [DATA_WIDTH-1:0] w_fwd_rs2;
  logic [DATA_WIDTH-1:0] w_a;

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src_idx      (r_rs1),
    .reg_data     (r_rs1_data),
    .mem_regwrite (bus.mem_regwrite),
    .mem_rd       (bus.mem_rd),
    .mem_result   (bus.mem_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_result    (bus.wb_result),
    .data         (w_fwd_rs1)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src_idx      (r_rs2),
    .reg_data     (r_rs2_data),
    .mem_regwrite (bus.mem_regwrite),
    .mem_rd       (bus.mem_rd),
    .mem_result   (bus.mem_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_result    (bus.wb_result),
    .data         (w_fwd_rs2)
  );

  always_comb begin
    w_a = '0;
    case (r_ctrl.src_a)
      SRC_A_RS1:  w_a = w_fwd_rs1;
      SRC_A_PC:   w_a = r_pc;
      SRC_A_ZERO: w_a = '0;
      default:    w_a = '0;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign bus.id_stall      = w_stall;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_A          = w_a;
  assign bus.ex_B          = (r_ctrl.src_b == SRC_B_IMM) ? r_imm : w_fwd_rs2;
  assign bus.ex_ALUCtl     = r_ctrl.alu_ctl;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_regwrite   = r_ctrl.regwrite;
  assign bus.ex_memread    = r_ctrl.memread;
  assign bus.ex_memwrite   = r_ctrl.memwrite;
  assign bus.ex_branch     = r_ctrl.branch;
  assign bus.ex_branch_ne  = r_ctrl.branch_ne;
  assign bus.ex_store_data = w_fwd_rs2;
  assign bus.ex_illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ex_operand_stage                                              |
// | Purpose : Scoreboard bench for ex_operand_stage. Directed instructions     |
// |           push their hand-computed EX record into a queue. A monitor pops  |
// |           and compares on every cycle that ex_valid is high. Stall,        |
// |           bubble, illegal and reset behaviour are checked inline.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ex_operand_stage;
  import ex_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        bne;
    logic [31:0] sd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  ex_operand_stage_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) bus ();

  ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
    bus.id_valid    = v;
    bus.id_opcode   = opc;
    bus.id_funct3   = f3;
    bus.id_funct7_5 = f7;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_rs1_data = d1;
    bus.id_rs2_data = d2;
    bus.id_imm      = imm;
    bus.id_pc       = pc;
  endtask

  task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    bus.mem_regwrite = mrw;
    bus.mem_rd       = mrd;
    bus.mem_result   = mres;
    bus.wb_regwrite  = wrw;
    bus.wb_rd        = wrd;
    bus.wb_result    = wres;
  endtask

  task automatic expect_ex(input logic [31:0] a, input logic [31:0] b, input logic [3:0] alu,
                           input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                           input logic br, input logic bne, input logic [31:0] sd);
    exp_t e;
    e = '{a: a, b: b, alu: alu, rd: rd, rw: rw, mr: mr, mw: mw, br: br, bne: bne, sd: sd};
    sb_q.push_back(e);
  endtask

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t act;
    exp_t req;
    if (rst_n === 1'b1 && bus.ex_valid === 1'b1) begin
      act = '{a: bus.ex_A, b: bus.ex_B, alu: bus.ex_ALUCtl, rd: bus.ex_rd,
              rw: bus.ex_regwrite, mr: bus.ex_memread, mw: bus.ex_memwrite,
              br: bus.ex_branch, bne: bus.ex_branch_ne, sd: bus.ex_store_data};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL ex_record: unexpected valid output A=%h B=%h ctl=%h", act.a, act.b, act.alu);
      end else begin
        req = sb_q.pop_front();
        if (act !== req) begin
          n_bad++;
          $display("FAIL ex_record: got A=%h B=%h ctl=%h rd=%0d rw/mr/mw/br/ne=%b%b%b%b%b sd=%h expected A=%h B=%h ctl=%h rd=%0d rw/mr/mw/br/ne=%b%b%b%b%b sd=%h",
                   act.a, act.b, act.alu, act.rd, act.rw, act.mr, act.mw, act.br, act.bne, act.sd,
                   req.a, req.b, req.alu, req.rd, req.rw, req.mr, req.mw, req.br, req.bne, req.sd);
        end
      end
    end
  end

  // ------------------------------------------------------------ watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.flush = 1'b0;
    set_id(1'b0, 7'h00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("reset_regwrite", {31'b0, bus.ex_regwrite}, 32'h0);
    check("reset_aluctl", {28'b0, bus.ex_ALUCtl}, {28'b0, ALU_ADD});
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // R-type SUB x3 = x1 - x2
    set_id(1'b1, OP_RTYPE, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'h0, 32'h0);
    expect_ex(32'd10, 32'd3, ALU_SUB, 5'd3, 1, 0, 0, 0, 0, 32'd3);
    tick();
    // ADD rs1=x5: MEM and WB both hit x5 while it is in EX
    set_id(1'b1, OP_RTYPE, 3'b000, 1'b0, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 32'h0, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_ex(32'h55, 32'h22, ALU_ADD, 5'd8, 1, 0, 0, 0, 0, 32'h22);
    tick();
    // AND x5,x5: MEM write disabled, WB supplies both
    set_id(1'b1, OP_RTYPE, 3'b111, 1'b0, 5'd5, 5'd5, 5'd9, 32'h11, 32'h22, 32'h0, 32'h0);
    set_fwd(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'h77);
    expect_ex(32'h77, 32'h77, ALU_AND, 5'd9, 1, 0, 0, 0, 0, 32'h77);
    tick();
    // XOR x0,x0: producers targeting x0 never forward
    set_id(1'b1, OP_RTYPE, 3'b100, 1'b0, 5'd0, 5'd0, 5'd4, 32'h12, 32'h34, 32'h0, 32'h0);
    set_fwd(1'b0, 5'd5, 32'h55, 1'b1, 5'd5, 32'h77);
    expect_ex(32'h12, 32'h34, ALU_XOR, 5'd4, 1, 0, 0, 0, 0, 32'h34);
    tick();
    // ADDI with instr[30]=1 stays ADD; B is imm, store data still forwarded
    set_id(1'b1, OP_ITYPE, 3'b000, 1'b1, 5'd2, 5'd7, 5'd5, 32'd100, 32'h999, 32'hFFFF_FFFB, 32'h0);
    set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
    expect_ex(32'd100, 32'hFFFF_FFFB, ALU_ADD, 5'd5, 1, 0, 0, 0, 0, 32'hAAA);
    tick();
    // SLTI
    set_id(1'b1, OP_ITYPE, 3'b010, 1'b0, 5'd3, 5'd0, 5'd6, 32'd7, 32'd0, 32'd9, 32'h0);
    set_fwd(1'b1, 5'd7, 32'hAAA, 1'b0, 5'd0, 32'h0);
    expect_ex(32'd7, 32'd9, ALU_SLT, 5'd6, 1, 0, 0, 0, 0, 32'd0);
    tick();
    // LUI: A is zero even with a MEM hit on the rs1 field
    set_id(1'b1, OP_LUI, 3'b000, 1'b0, 5'd1, 5'd0, 5'd10, 32'hDEAD, 32'h0, 32'h1234_5000, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_ex(32'h0, 32'h1234_5000, ALU_ADD, 5'd10, 1, 0, 0, 0, 0, 32'h0);
    tick();
    // AUIPC
    set_id(1'b1, OP_AUIPC, 3'b000, 1'b0, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h2000, 32'h1000);
    set_fwd(1'b1, 5'd1, 32'hBEEF, 1'b0, 5'd0, 32'h0);
    expect_ex(32'h1000, 32'h2000, ALU_ADD, 5'd11, 1, 0, 0, 0, 0, 32'h0);
    tick();
    // SW: store data forwarded from WB
    set_id(1'b1, OP_STORE, 3'b010, 1'b0, 5'd2, 5'd4, 5'd0, 32'h100, 32'h44, 32'd8, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_ex(32'h100, 32'd8, ALU_ADD, 5'd0, 0, 0, 1, 0, 0, 32'h4444);
    tick();
    // BNE
    set_id(1'b1, OP_BRANCH, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'h10, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4444);
    expect_ex(32'd5, 32'd6, ALU_SUB, 5'd0, 0, 0, 0, 1, 1, 32'd6);
    tick();
    // BEQ
    set_id(1'b1, OP_BRANCH, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd9, 32'd9, 32'h10, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_ex(32'd9, 32'd9, ALU_SUB, 5'd0, 0, 0, 0, 1, 0, 32'd9);
    tick();
    // LW x6, 4(x1)
    set_id(1'b1, OP_LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd6, 32'h200, 32'h0, 32'd4, 32'h0);
    expect_ex(32'h200, 32'd4, ALU_ADD, 5'd6, 1, 1, 0, 0, 0, 32'h0);
    tick();
    // ADD x7, x6, x1 right behind the load
    set_id(1'b1, OP_RTYPE, 3'b000, 1'b0, 5'd6, 5'd1, 5'd7, 32'h0, 32'h10, 32'h0, 32'h0);
    expect_ex(32'h600, 32'h10, ALU_ADD, 5'd7, 1, 0, 0, 0, 0, 32'h10);
    #1;
    check("loaduse_stall", {31'b0, bus.id_stall}, 32'h1);
    tick();
    check("loaduse_bubble", {31'b0, bus.ex_valid}, 32'h0);
    check("loaduse_stall_once", {31'b0, bus.id_stall}, 32'h0);
    tick();
    // ADD now in EX with the load in WB; next ID is another LW x6
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h600);
    set_id(1'b1, OP_LOAD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd6, 32'h200, 32'h0, 32'd4, 32'h0);
    expect_ex(32'h200, 32'd4, ALU_ADD, 5'd6, 1, 1, 0, 0, 0, 32'h0);
    tick();
    // Dependent ADD arrives together with a flush
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, OP_RTYPE, 3'b000, 1'b0, 5'd6, 5'd1, 5'd7, 32'h0, 32'h10, 32'h0, 32'h0);
    bus.flush = 1'b1;
    #1;
    check("flush_no_stall", {31'b0, bus.id_stall}, 32'h0);
    tick();
    bus.flush = 1'b0;
    check("flush_bubble", {31'b0, bus.ex_valid}, 32'h0);
    // Unsupported opcode (SYSTEM)
    set_id(1'b1, 7'b1110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 32'h0);
    tick();
    check("illegal_pulse", {31'b0, bus.ex_illegal}, 32'h1);
    check("illegal_bubble", {31'b0, bus.ex_valid}, 32'h0);
    set_id(1'b0, 7'h00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("illegal_pulse_end", {31'b0, bus.ex_illegal}, 32'h0);
    // OR, then reset while it sits in EX
    set_id(1'b1, OP_RTYPE, 3'b110, 1'b0, 5'd1, 5'd2, 5'd5, 32'hF0, 32'h0F, 32'h0, 32'h0);
    expect_ex(32'hF0, 32'h0F, ALU_OR, 5'd5, 1, 0, 0, 0, 0, 32'h0F);
    tick();
    set_id(1'b0, 7'h00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("midreset_regwrite", {31'b0, bus.ex_regwrite}, 32'h0);
    check("midreset_aluctl", {28'b0, bus.ex_ALUCtl}, {28'b0, ALU_ADD});
    check("midreset_ex_A", bus.ex_A, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX boundary of the RISC-V core. Registers the decoded instruction and generates the ALU control code from opcode/funct3/funct7.
- Selects the ALU operands and applies forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts bubbles.
- Outputs drive the alu block's A, B and ALUCtl inputs directly.

Parameters:
- DATA_WIDTH, 32, datapath width of operands, PC, immediate and forwarded results.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_pc  in  DATA_WIDTH  instruction PC
- id_opcode  in  7  instruction[6:0]
- id_funct3  in  3  instruction[14:12]
- id_funct7_5  in  1  instruction[30]
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register indices
- id_rs1_data, id_rs2_data  in  DATA_WIDTH each  register file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- flush  in  1  branch redirect; kill the ID instruction
- mem_regwrite  in  1  MEM-stage instruction writes rd
- mem_rd  in  REG_ADDR_W  MEM-stage destination
- mem_result  in  DATA_WIDTH  MEM-stage ALU result
- wb_regwrite  in  1  WB-stage instruction writes rd
- wb_rd  in  REG_ADDR_W  WB-stage destination
- wb_result  in  DATA_WIDTH  WB-stage writeback value
- id_stall  out  1  hold PC and the IF/ID register this cycle
- ex_valid  out  1  EX stage holds a valid instruction
- ex_A, ex_B  out  DATA_WIDTH each  ALU operands
- ex_ALUCtl  out  4  ALU control code
- ex_rd  out  REG_ADDR_W  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  control flags
- ex_branch_ne  out  1  branch is BNE (else BEQ)
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
- ex_illegal  out  1  one-cycle pulse: an unsupported instruction was dropped

Behaviour:
- Reset (async, rst_n low): all registered fields cleared to 0; ex_valid=0, flags=0, ex_ALUCtl=ALU_ADD.
- Decode (combinational on id_*):
  - R-type 0110011:
    - funct3 000 -> ADD, or SUB when funct7_5=1
    - 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT
    - regwrite=1
  - I-type 0010011: same funct3 map, always ADD for 000; B=imm; regwrite=1.
  - Load 0000011: ADD, B=imm, memread=1, regwrite=1.
  - Store 0100011: ADD, B=imm, memwrite=1.
  - Branch 1100011: funct3 000 (BEQ) / 001 (BNE) -> SUB, B=rs2, branch=1, branch_ne=funct3[0].
  - LUI 0110111: A=0, B=imm, ADD, regwrite=1.
  - AUIPC 0010111: A=pc, B=imm, ADD, regwrite=1.
  - Anything else: illegal.
- Register update each posedge, priority flush > stall > illegal > load:
  - flush=1: bubble (ex_valid=0, all flags 0).
  - id_stall=1: bubble.
  - illegal && id_valid: bubble; ex_illegal=1 for one cycle.
  - otherwise: latch the decoded fields; ex_valid=id_valid; flags are ANDed with id_valid.
  - Latency from ID to ex_* outputs: 1 cycle.
- Load-use hazard: id_stall = id_valid & ~flush & ex_valid & ex_memread & ex_rd!=0 & ((ex_rd==id_rs1 & uses_rs1) | (ex_rd==id_rs2 & uses_rs2)).
  - uses_rs1 is 0 for LUI/AUIPC.
  - uses_rs2 is 1 only for R-type, store and branch.
  - Combinational output.
  - Produces exactly one bubble per load-use pair.
- Forwarding (combinational on the registered rs1/rs2 values and the mem_*/wb_* inputs):
  - Per operand: the MEM match wins over the WB match; otherwise the registered register-file value is used.
  - A match requires regwrite=1, rd!=0 and rd equal to the registered source index.
  - ex_A applies the forwarded rs1 only when the A source is rs1.
  - ex_B applies the forwarded rs2 only when the B source is rs2.
  - ex_store_data always uses the forwarded rs2.
- During a bubble, ex_A/ex_B values are don't-care but must be deterministic (held fields are zero).
- Reset mid-operation: outputs are cleared immediately and asynchronously. No partial state survives.

Decomposition:
- Shared package ex_pkg holds:
  - opcode constants
  - operand-source enums (SRC_A_RS1/PC/ZERO, SRC_B_RS2/IMM)
  - the packed EX-control struct
- ALU_* codes are imported from the existing ALU control definitions; no new encodings are introduced.
- One sub-module, fwd_mux: a single-operand forwarding selector, instantiated twice.

Test Plan:
- Reset: rst_n=0 mid-stream -> ex_valid=0, ex_regwrite=0, ex_ALUCtl=ALU_ADD immediately, with no clock edge required.
- Decode: R-type SUB with rs1 data 10, rs2 data 3 -> next cycle ex_ALUCtl=ALU_SUB, ex_A=10, ex_B=3, ex_regwrite=1.
- Forwarding:
  - mem_rd=5, mem_result=0x55, wb_rd=5, wb_result=0x77, EX rs1=5 -> ex_A=0x55 (MEM priority).
  - With mem_regwrite=0 -> ex_A=0x77.
  - With rd=0 -> no forwarding.
- Load-use: LW x6 followed by ADD x7,x6,x1 -> id_stall=1 for one cycle and one bubble (ex_valid=0). The ADD then issues with x6 forwarded from WB.
- Flush: flush=1 together with a pending stall -> id_stall=0, ex_valid=0 next cycle.
- Illegal: opcode 1110011 with id_valid=1 -> ex_valid=0 and an ex_illegal pulse of exactly one cycle.
